// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared types, default sizes and helpers for the vector register file
package vrf_pkg;

   localparam int unsigned VRF_BITS  = 8;
   localparam int unsigned VRF_N     = 4;
   localparam int unsigned VRF_NREGS = 16;
   localparam int unsigned VRF_NRD   = 2;

   typedef logic [VRF_BITS-1:0]          elem_t;
   typedef elem_t                        vec_t [VRF_N];
   typedef logic [$clog2(VRF_N+1)-1:0]   len_t;

   localparam vec_t ZERO_VEC = '{default: '0};

   // Lengths above the vector size saturate rather than wrap.
   function automatic int unsigned clamp_len(int unsigned len, int unsigned n);
      return (len > n) ? n : len;
   endfunction

endpackage

// File: rtl/vrf_read_port.sv
// rtl/vrf_read_port.sv - one registered read port: select mux, range check, optional write bypass
module vrf_read_port #(
   parameter int unsigned BITS  = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned NREGS = 16,
   parameter int unsigned SEL_W = $clog2(NREGS),
   parameter int unsigned LEN_W = $clog2(N+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [BITS-1:0]  regs_i [NREGS][N],
   input  logic [LEN_W-1:0] lens_i [NREGS],
   input  logic [NREGS-1:0] pending_i,
`ifdef VRF_BYPASS_EN
   input  logic             wr_en_i,
   input  logic [SEL_W-1:0] wr_sel_i,
   input  logic [BITS-1:0]  wr_data_i [N],
   input  logic [LEN_W-1:0] wr_len_i,
`endif
   output logic [BITS-1:0]  data_o [N],
   output logic [LEN_W-1:0] len_o,
   output logic             busy_o
);

   logic [BITS-1:0]  data_q [N];
   logic [BITS-1:0]  data_d [N];
   logic [LEN_W-1:0] len_q, len_d;
   logic             busy_q, busy_d;
   logic             hit;

   assign hit = en_i && (32'(sel_i) < NREGS);

   always_comb begin
      data_d = '{default: '0};
      len_d  = '0;
      busy_d = 1'b0;
      if (hit) begin
         data_d = regs_i[sel_i];
         len_d  = lens_i[sel_i];
         busy_d = pending_i[sel_i];
`ifdef VRF_BYPASS_EN
         // The writeback on this edge also clears pending, so the forwarded value is never busy.
         if (wr_en_i && (wr_sel_i == sel_i)) begin
            data_d = wr_data_i;
            len_d  = wr_len_i;
            busy_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '{default: '0};
         len_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         data_q <= data_d;
         len_q  <= len_d;
         busy_q <= busy_d;
      end
   end

   assign data_o = data_q;
   assign len_o  = len_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/vec_reg_file.sv
// rtl/vec_reg_file.sv - vector register file with scoreboard and registered read ports; VRF_BYPASS_EN forwards same-edge writes
module vec_reg_file
   import vrf_pkg::*;
#(
   parameter int unsigned BITS  = VRF_BITS,
   parameter int unsigned N     = VRF_N,
   parameter int unsigned NREGS = VRF_NREGS,
   parameter int unsigned NRD   = VRF_NRD,
   parameter int unsigned SEL_W = $clog2(NREGS),
   parameter int unsigned LEN_W = $clog2(N+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [BITS-1:0]           in_i [N],
   input  logic [LEN_W-1:0]          in_len_i,
   input  logic [SEL_W-1:0]          in_sel_i,
   input  logic                      write_i,
   input  logic                      rsv_valid_i,
   input  logic [SEL_W-1:0]          rsv_sel_i,
   output logic                      rsv_ready_o,
   input  logic [NRD-1:0][SEL_W-1:0] rd_sel_i,
   input  logic [NRD-1:0]            rd_en_i,
   output logic [BITS-1:0]           rd_data_o [NRD][N],
   output logic [NRD-1:0][LEN_W-1:0] rd_len_o,
   output logic [NRD-1:0]            rd_busy_o,
   output logic [NREGS-1:0]          pending_o
);

   logic [BITS-1:0]  regs_q [NREGS][N];
   logic [LEN_W-1:0] len_q  [NREGS];
   logic [NREGS-1:0] pending_q, pending_d;

   logic             wr_hit;
   logic [LEN_W-1:0] wr_len;
   logic [BITS-1:0]  wr_vec [N];

   assign wr_hit = write_i && (32'(in_sel_i) < NREGS);
   assign wr_len = LEN_W'(clamp_len(32'(in_len_i), N));

   always_comb begin
      for (int i = 0; i < N; i++) begin
         wr_vec[i] = (i < int'(wr_len)) ? in_i[i] : '0;
      end
   end

   assign rsv_ready_o = rsv_valid_i && (32'(rsv_sel_i) < NREGS) && !pending_q[rsv_sel_i];

   // Reserve is applied after the writeback clear so a same-register collision ends pending.
   always_comb begin
      pending_d = pending_q;
      if (wr_hit)      pending_d[in_sel_i]  = 1'b0;
      if (rsv_ready_o) pending_d[rsv_sel_i] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q    <= '{default: '0};
         len_q     <= '{default: '0};
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
         if (wr_hit) begin
            regs_q[in_sel_i] <= wr_vec;
            len_q[in_sel_i]  <= wr_len;
         end
      end
   end

   assign pending_o = pending_q;

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      vrf_read_port #(
         .BITS  (BITS),
         .N     (N),
         .NREGS (NREGS),
         .SEL_W (SEL_W),
         .LEN_W (LEN_W)
      ) u_rd (
         .clk       (clk),
         .rst       (rst),
         .en_i      (rd_en_i[p]),
         .sel_i     (rd_sel_i[p]),
         .regs_i    (regs_q),
         .lens_i    (len_q),
         .pending_i (pending_q),
`ifdef VRF_BYPASS_EN
         .wr_en_i   (wr_hit),
         .wr_sel_i  (in_sel_i),
         .wr_data_i (wr_vec),
         .wr_len_i  (wr_len),
`endif
         .data_o    (rd_data_o[p]),
         .len_o     (rd_len_o[p]),
         .busy_o    (rd_busy_o[p])
      );
   end

endmodule

// File: tb/tb_vec_reg_file.sv
// tb/tb_vec_reg_file.sv - randomized self-checking bench for vec_reg_file against a behavioural model
module tb_vec_reg_file;

   localparam int BITS  = 8;
   localparam int N     = 4;
   localparam int NREGS = 16;
   localparam int NRD   = 2;
   localparam int SEL_W = 4;
   localparam int LEN_W = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [BITS-1:0]           in_v [N];
   logic [LEN_W-1:0]          in_len;
   logic [SEL_W-1:0]          in_sel;
   logic                      write;
   logic                      rsv_valid;
   logic [SEL_W-1:0]          rsv_sel;
   logic                      rsv_ready;
   logic [NRD-1:0][SEL_W-1:0] rd_sel;
   logic [NRD-1:0]            rd_en;
   logic [BITS-1:0]           rd_data [NRD][N];
   logic [NRD-1:0][LEN_W-1:0] rd_len;
   logic [NRD-1:0]            rd_busy;
   logic [NREGS-1:0]          pending;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: plain integers per register.
   int unsigned m_data [NREGS][N];
   int unsigned m_len  [NREGS];
   bit          m_pend [NREGS];

   always #5 clk = ~clk;

   vec_reg_file dut (
      .clk         (clk),
      .rst         (rst),
      .in_i        (in_v),
      .in_len_i    (in_len),
      .in_sel_i    (in_sel),
      .write_i     (write),
      .rsv_valid_i (rsv_valid),
      .rsv_sel_i   (rsv_sel),
      .rsv_ready_o (rsv_ready),
      .rd_sel_i    (rd_sel),
      .rd_en_i     (rd_en),
      .rd_data_o   (rd_data),
      .rd_len_o    (rd_len),
      .rd_busy_o   (rd_busy),
      .pending_o   (pending)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dut_vec(input int p);
      return {rd_data[p][3], rd_data[p][2], rd_data[p][1], rd_data[p][0]};
   endfunction

   function automatic logic [31:0] model_vec(input int r);
      int unsigned v = 0;
      for (int i = 0; i < N; i++) v += m_data[r][i] << (8 * i);
      return v;
   endfunction

   function automatic logic [15:0] model_pend();
      logic [15:0] v = '0;
      for (int r = 0; r < NREGS; r++) v[r] = m_pend[r];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_len[r]  = 0;
         m_pend[r] = 0;
         for (int i = 0; i < N; i++) m_data[r][i] = 0;
      end
   endtask

   task automatic idle();
      write     = 0;
      in_len    = '0;
      in_sel    = '0;
      rsv_valid = 0;
      rsv_sel   = '0;
      rd_en     = '0;
      rd_sel    = '0;
      for (int i = 0; i < N; i++) in_v[i] = '0;
   endtask

   task automatic set_write(input int sel, input int len, input logic [31:0] d);
      write  = 1;
      in_sel = SEL_W'(sel);
      in_len = LEN_W'(len);
      for (int i = 0; i < N; i++) in_v[i] = d[8*i +: 8];
   endtask

   // Called with inputs applied between edges; checks rsv_ready now and everything after the edge.
   task automatic cycle();
      bit          exp_rdy;
      logic [31:0] exp_d [NRD];
      int unsigned exp_l [NRD];
      bit          exp_b [NRD];
      int unsigned eff;
      #1;
      exp_rdy = rsv_valid && !m_pend[rsv_sel];
      check("rsv_ready", 64'(rsv_ready), 64'(exp_rdy));
      eff = (in_len > N) ? N : in_len;
      for (int p = 0; p < NRD; p++) begin
         exp_d[p] = 0; exp_l[p] = 0; exp_b[p] = 0;
         if (rd_en[p]) begin
            exp_d[p] = model_vec(rd_sel[p]);
            exp_l[p] = m_len[rd_sel[p]];
            exp_b[p] = m_pend[rd_sel[p]];
`ifdef VRF_BYPASS_EN
            if (write && rd_sel[p] == in_sel) begin
               exp_d[p] = 0;
               for (int i = 0; i < eff; i++) exp_d[p] += 32'(in_v[i]) << (8 * i);
               exp_l[p] = eff;
               exp_b[p] = 0;
            end
`endif
         end
      end
      if (write) begin
         m_len[in_sel]  = eff;
         m_pend[in_sel] = 0;
         for (int i = 0; i < N; i++) m_data[in_sel][i] = (i < eff) ? in_v[i] : 0;
      end
      if (exp_rdy) m_pend[rsv_sel] = 1;
      @(posedge clk);
      #1;
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("rd_data[%0d]", p), 64'(dut_vec(p)), 64'(exp_d[p]));
         check($sformatf("rd_len[%0d]", p), 64'(rd_len[p]), 64'(exp_l[p]));
         check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(exp_b[p]));
      end
      check("pending", 64'(pending), 64'(model_pend()));
   endtask

   initial begin
      idle();
      model_reset();
      rst       = 1;
      rsv_valid = 1;
      #3;
      check("reset_pending", 64'(pending), 64'h0);
      check("reset_rd_data0", 64'(dut_vec(0)), 64'h0);
      check("reset_rd_len", 64'(rd_len), 64'h0);
      check("reset_rsv_ready", 64'(rsv_ready), 64'h1);
      #9 rst = 0;
      idle();
      @(posedge clk); #1;

      // masked write, read one cycle later
      set_write(0, 2, 32'h55AA3C0F); cycle();
      idle(); rd_en[0] = 1; rd_sel[0] = 0; cycle();
      check("masked_data", 64'(dut_vec(0)), 64'h00003C0F);
      check("masked_len", 64'(rd_len[0]), 64'd2);

      // length clamp
      set_write(3, 7, 32'h44332211); cycle();
      idle(); rd_en[0] = 1; rd_sel[0] = 3; cycle();
      check("clamp_len", 64'(rd_len[0]), 64'd4);

      // scoreboard reserve/release
      idle(); rsv_valid = 1; rsv_sel = 2; cycle();
      idle(); rsv_valid = 1; rsv_sel = 2; #1;
      check("rsv_reject", 64'(rsv_ready), 64'h0);
      cycle();
      idle(); set_write(2, 4, 32'hDEADBEEF); cycle();
      idle(); rsv_valid = 1; rsv_sel = 2; cycle();

      // same-cycle write and reserve on r4, first free then pending
      idle(); set_write(4, 4, 32'h01020304); rsv_valid = 1; rsv_sel = 4; cycle();
      check("wr_rsv_free", 64'(pending[4]), 64'h1);
      idle(); set_write(4, 1, 32'h000000AB); rsv_valid = 1; rsv_sel = 4; cycle();
      check("wr_rsv_busy", 64'(pending[4]), 64'h0);

      // read of the register written on the same edge
      idle(); set_write(1, 4, 32'h04030201); cycle();
      idle(); set_write(1, 3, 32'h117D7EFF); rd_en[1] = 1; rd_sel[1] = 1; cycle();
`ifdef VRF_BYPASS_EN
      check("bypass_data", 64'(dut_vec(1)), 64'h007D7EFF);
`else
      check("bypass_data", 64'(dut_vec(1)), 64'h04030201);
`endif

      // disabled port next to an active one
      idle(); rd_en[1] = 1; rd_sel[1] = 2; rd_sel[0] = 2; cycle();
      check("rd_dis_zero", 64'(dut_vec(0)), 64'h0);

      // asynchronous reset between edges
      idle(); set_write(3, 4, 32'hCAFEF00D); rsv_valid = 1; rsv_sel = 5;
      rd_en = 2'b11; rd_sel[0] = 0; rd_sel[1] = 3; cycle();
      idle();
      rst = 1;
      #1;
      check("arst_pending", 64'(pending), 64'h0);
      check("arst_rd0", 64'(dut_vec(0)), 64'h0);
      check("arst_rd1", 64'(dut_vec(1)), 64'h0);
      check("arst_busy", 64'(rd_busy), 64'h0);
      model_reset();
      #2 rst = 0;
      rd_en[0] = 1; rd_sel[0] = 3; cycle();
      check("arst_r3", 64'(dut_vec(0)), 64'h0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         idle();
         if ($urandom_range(0, 1) == 1)
            set_write($urandom_range(0, NREGS-1), $urandom_range(0, 7), $urandom);
         rsv_valid = ($urandom_range(0, 2) != 0);
         rsv_sel   = SEL_W'($urandom_range(0, NREGS-1));
         rd_en     = NRD'($urandom_range(0, 3));
         rd_sel[0] = SEL_W'($urandom_range(0, NREGS-1));
         rd_sel[1] = ($urandom_range(0, 3) == 0) ? in_sel : SEL_W'($urandom_range(0, NREGS-1));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
